// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage with a handshaked data-SRAM port.
//   Holds the EX->MEM register, issues one SRAM access per memory
//   instruction (request/accept, then data/complete with variable latency),
//   places store bytes on lanes, extracts/extends load data, flags misaligned
//   accesses and requests a pipeline stall while an access is outstanding.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    stall vector; bit STG controls this register
//   ex_*                     EX-stage results to capture
//   data_req/wr/wstrb/addr/wdata, data_addr_ok/data_ok/rdata   SRAM port
//   stallreq_mem             access outstanding, hold the pipeline
//   mem_err                  one-cycle pulse on a misaligned access
//   wb_*                     results towards WB and the ID forward path
module mem_stage_lsu #(
    parameter int RF_AW   = 5,
    parameter int HL_EN   = 1,
    parameter int STALL_W = 6,
    parameter int STG     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [31:0]        ex_pc,
    input  logic               ex_mem_en,
    input  logic               ex_is_store,
    input  logic [1:0]         ex_size,
    input  logic               ex_sign,
    input  logic               ex_rf_we,
    input  logic [RF_AW-1:0]   ex_rf_waddr,
    input  logic [31:0]        ex_result,
    input  logic [31:0]        ex_store_data,
    input  logic [1:0]         ex_hl_we,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    output logic               data_req,
    output logic               data_wr,
    output logic [3:0]         data_wstrb,
    output logic [31:0]        data_addr,
    output logic [31:0]        data_wdata,
    input  logic               data_addr_ok,
    input  logic               data_data_ok,
    input  logic [31:0]        data_rdata,
    output logic               stallreq_mem,
    output logic               mem_err,
    output logic [31:0]        wb_pc,
    output logic               wb_rf_we,
    output logic [RF_AW-1:0]   wb_rf_waddr,
    output logic [31:0]        wb_rf_wdata,
    output logic [1:0]         wb_hl_we,
    output logic [31:0]        wb_hi,
    output logic [31:0]        wb_lo
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;

    logic [31:0]      pc_q;
    logic             mem_en_q;
    logic             is_store_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic             rf_we_q;
    logic [RF_AW-1:0] rf_waddr_q;
    logic [31:0]      result_q;
    logic [31:0]      sdata_q;
    logic [1:0]       hl_we_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             first_q;   // set only in the first cycle an instruction sits in MEM
    logic [31:0]      rdata_q;

    logic             capture;
    logic             bubble;
    logic             misaligned;
    logic             mem_go;
    logic             req_phase;
    logic             complete_now;
    logic             done;
    logic             pending;
    logic [31:0]      load_word;
    logic [31:0]      load_shift;
    logic [31:0]      load_val;
    logic [15:0]      load_half;

    assign capture = !stall[STG];
    assign bubble  = stall[STG] && !stall[STG+1];

    assign misaligned = (size_q == 2'd1 && result_q[0]) ||
                        (size_q == 2'd2 && result_q[1:0] != 2'b00);
    assign mem_go     = mem_en_q && !misaligned;
    assign done       = (state_q == S_DONE);
    assign req_phase  = mem_go && (state_q == S_IDLE || state_q == S_REQ);
    // Completion is either a zero-wait accept+data or data arriving in WAIT.
    assign complete_now = (req_phase && data_addr_ok && data_data_ok) ||
                          (mem_go && state_q == S_WAIT && data_data_ok);
    assign pending      = mem_go && !done && !complete_now;

    // EX->MEM register
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            pc_q       <= '0;
            mem_en_q   <= 1'b0;
            is_store_q <= 1'b0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
            sdata_q    <= '0;
            hl_we_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            first_q    <= 1'b0;
        end else if (capture) begin
            pc_q       <= ex_pc;
            mem_en_q   <= ex_mem_en;
            is_store_q <= ex_is_store;
            size_q     <= ex_size;
            sign_q     <= ex_sign;
            rf_we_q    <= ex_rf_we;
            rf_waddr_q <= ex_rf_waddr;
            result_q   <= ex_result;
            sdata_q    <= ex_store_data;
            hl_we_q    <= ex_hl_we;
            hi_q       <= ex_hi;
            lo_q       <= ex_lo;
            first_q    <= 1'b1;
        end else begin
            first_q    <= 1'b0;
        end
    end

    // Access FSM; any new register contents restart it in IDLE.
    always_ff @(posedge clk) begin
        if (rst || bubble || capture) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_REQ: begin
                if (mem_go) begin
                    if (data_addr_ok) begin
                        state_d = data_data_ok ? S_DONE : S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_WAIT:  if (data_data_ok) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data is kept only from the completion cycle, so DONE never sees a later beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (complete_now && !is_store_q) begin
            rdata_q <= data_rdata;
        end
    end

    // Load extraction
    always_comb begin
        if (done) begin
            load_word = rdata_q;
        end else if (complete_now) begin
            load_word = data_rdata;
        end else begin
            load_word = '0;
        end
        load_shift = load_word >> {result_q[1:0], 3'b000};
        load_half  = result_q[1] ? load_word[31:16] : load_word[15:0];
        case (size_q)
            2'd0:    load_val = sign_q ? {{24{load_shift[7]}}, load_shift[7:0]}
                                       : {24'b0, load_shift[7:0]};
            2'd1:    load_val = sign_q ? {{16{load_half[15]}}, load_half}
                                       : {16'b0, load_half};
            default: load_val = load_word;
        endcase
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        data_req     = 1'b0;
        data_wr      = 1'b0;
        data_wstrb   = '0;
        data_addr    = '0;
        data_wdata   = '0;
        stallreq_mem = 1'b0;
        mem_err      = 1'b0;
        wb_pc        = '0;
        wb_rf_we     = 1'b0;
        wb_rf_waddr  = '0;
        wb_rf_wdata  = '0;
        wb_hl_we     = '0;
        wb_hi        = '0;
        wb_lo        = '0;
        if (!rst) begin
            data_req  = req_phase;
            data_wr   = req_phase && is_store_q;
            data_addr = req_phase ? result_q : '0;
            if (req_phase && is_store_q) begin
                case (size_q)
                    2'd0: begin
                        data_wstrb = 4'b0001 << result_q[1:0];
                        data_wdata = {4{sdata_q[7:0]}};
                    end
                    2'd1: begin
                        data_wstrb = result_q[1] ? 4'b1100 : 4'b0011;
                        data_wdata = {2{sdata_q[15:0]}};
                    end
                    default: begin
                        data_wstrb = 4'b1111;
                        data_wdata = sdata_q;
                    end
                endcase
            end
            stallreq_mem = pending;
            mem_err      = mem_en_q && misaligned && first_q;
            wb_pc        = pc_q;
            wb_rf_we     = rf_we_q && !(mem_en_q && misaligned) && !pending;
            wb_rf_waddr  = rf_waddr_q;
            wb_rf_wdata  = (mem_go && !is_store_q) ? load_val : result_q;
            wb_hl_we     = (HL_EN != 0) ? hl_we_q : 2'b00;
            wb_hi        = hi_q;
            wb_lo        = lo_q;
        end
    end

endmodule
